gpio_in: RTL and testbench
==========================

# gpio_in

Memory-mapped general-purpose input peripheral: the input-direction counterpart of the core's GPIO output port. Each external pin passes through a two-flop synchronizer and a per-pin debounce filter. The block records sticky rising/falling-edge flags and exposes level, edge and enable registers on the core's load/store path, decoded from the ALU address. An `IRQ` line is provided for a future interrupt controller.

## Interface
Parameters:
- `WIDTH`, 4: number of input pins (1..32).
- `DEBOUNCE_CYCLES`, 16: consecutive stable-mismatch cycles required to accept a new level (≥1); counter width is `$clog2(DEBOUNCE_CYCLES)` (min 1).
- `BASE_ADDR`, 32'h0000_2000: 16-byte-aligned register window base.

Ports:
- `CLK` in 1: single clock for all state.
- `RST` in 1: asynchronous, active-low reset.
- `PIN` in `WIDTH`: raw external inputs, asynchronous to `CLK`.
- `ADDR` in `MXLEN`: byte address (ALU output).
- `LOAD` in 1: load in progress this cycle.
- `STORE` in 1: store in progress this cycle.
- `WDATA` in `MXLEN`: store data (rs2).
- `RDATA` out `MXLEN`: read data, combinational from `ADDR`/`LOAD` and registered state.
- `IRQ` out 1: registered, high while any enabled edge flag is set.

## Operation
Register map (offset = `ADDR[3:2]`; hit when `ADDR[31:4] == BASE_ADDR[31:4]`; `ADDR[1:0]` ignored):
- 0x0 `LEVEL`: RO, debounced pin levels, zero-extended to `MXLEN`.
- 0x4 `RISE`: sticky rising-edge flags, write-1-to-clear.
- 0x8 `FALL`: sticky falling-edge flags, write-1-to-clear.
- 0xC `EN`: RW edge-interrupt enable mask; bits ≥ `WIDTH` read 0.

Per pin:
- sync0 ← `PIN`; sync1 ← sync0.
- If sync1 == stable: cnt ← 0.
- If sync1 != stable and cnt < `DEBOUNCE_CYCLES`-1: cnt ← cnt+1.
- If sync1 != stable and cnt == `DEBOUNCE_CYCLES`-1: stable ← sync1, cnt ← 0, and set `RISE` (new 1) or `FALL` (new 0).
- A glitch shorter than `DEBOUNCE_CYCLES` mismatch cycles resets cnt and never reaches stable.

Bus behaviour:
- `RDATA` = selected register when hit and `LOAD`, else 0.
- Stores take effect at the clock edge when hit and `STORE`. Any store is treated as a full word; byte/half width is ignored.
- A store to `LEVEL` has no effect.
- A write to `RISE`/`FALL` clears the bits where `WDATA` is 1.
- A write to `EN` loads `WDATA[WIDTH-1:0]`.

Boundary rules:
- Same-edge set and W1C of one flag: set wins and the flag stays 1.
- Set of an already-set flag: no change; events are not counted.
- `LOAD` and `STORE` both high: read returns the pre-store value.
- `IRQ` ← |((`RISE` | `FALL`) & `EN`), registered.

Reset (RST low, asynchronous): sync0, sync1, stable, cnt, `RISE`, `FALL`, `EN` and `IRQ` all go to 0; `RDATA` is therefore 0. A pin held high through reset release produces a `RISE` flag after the normal latency. This is intended: software clears `RISE` at boot.

## Timing
- Pin change (stable thereafter) → `LEVEL`/flag update on the (2+`DEBOUNCE_CYCLES`)-th rising edge after the change is sampled. With `DEBOUNCE_CYCLES`=1 this is the 3rd edge.
- Flag set → `IRQ` high one edge later.
- W1C or `EN` write → visible on `RDATA` the cycle after the store edge; `IRQ` drops one further edge later.
- Read latency 0 (combinational), matching the single-cycle core's load path.
- Reset asserted mid-debounce aborts the count; there is no partial acceptance.

## Structure
- `defs.v` holds `MXLEN`, plus the new `` `GPIN_LEVEL ``, `` `GPIN_RISE ``, `` `GPIN_FALL `` and `` `GPIN_EN `` offset constants and the default base address.
- Sub-module `gpio_in_debounce` covers one pin: synchronizer, counter and stable register, with outputs level, rise_pulse and fall_pulse. It is generate-instantiated `WIDTH` times.
- Flags, `EN`, `IRQ` and address decode live in `gpio_in`.
- The top level wires `ADDR`=alu_out, `LOAD`/`STORE` from the decoder, `WDATA`=rf_r_data2, and muxes `RDATA` into the load write-back when hit.

## Test plan
- Reset with `PIN`=4'b0000, release, hold 40 cycles → `LEVEL`=0, `RISE`=`FALL`=0, `IRQ`=0.
- `DEBOUNCE_CYCLES`=16, `PIN[2]` 0→1 held → `LEVEL` reads 4'b0100 and `RISE`=4'b0100 exactly on edge 18 after the change, not on edge 17.
- 10-cycle pulse on `PIN[0]` → `LEVEL`, `RISE` and `FALL` remain 0.
- `EN`←4'b0100, then rise on `PIN[2]` → `IRQ`=1 one edge after the flag. Store 4'b0100 to `RISE` → `RISE`=0, and `IRQ`=0 one edge later.
- W1C of `RISE[1]` on the same edge a new rise on pin 1 is accepted → `RISE[1]` stays 1.
- Assert `RST` low at debounce count 12, release → `LEVEL`=0, and a full 16-cycle count is required again.

Source files
------------

// File: rtl/gpio_in_pkg.sv
// Shared definitions for the gpio_in input peripheral: bus width, register
// offsets within the 16-byte window, default base address and helpers.
package gpio_in_pkg;

    localparam int MXLEN = 32;

    // Byte offsets of the registers inside the window.
    localparam logic [3:0] GPIN_LEVEL = 4'h0;
    localparam logic [3:0] GPIN_RISE  = 4'h4;
    localparam logic [3:0] GPIN_FALL  = 4'h8;
    localparam logic [3:0] GPIN_EN    = 4'hC;

    localparam logic [MXLEN-1:0] GPIN_BASE_DEFAULT = 32'h0000_2000;

    // Word select taken from ADDR[3:2].
    typedef enum logic [1:0] {
        REG_LEVEL = GPIN_LEVEL[3:2],
        REG_RISE  = GPIN_RISE[3:2],
        REG_FALL  = GPIN_FALL[3:2],
        REG_EN    = GPIN_EN[3:2]
    } gpin_reg_e;

    // Debounce counter width, never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/gpio_in_debounce.sv
// One input pin: two-flop synchronizer, stable-mismatch counter and accepted
// level, with single-cycle pulses on the edge where a new level is taken.
module gpio_in_debounce
    import gpio_in_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int              CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync0_p0;
    logic             sync1_p1;
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    // The mismatch is only ever towards ~stable, so one counter suffices.
    assign accept = (sync1_p1 != stable) && (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_p0 <= 1'b0;
            sync1_p1 <= 1'b0;
            stable   <= 1'b0;
            cnt      <= '0;
        end else begin
            // Stage p0 -> p1: metastability settling.
            sync0_p0 <= pin;
            sync1_p1 <= sync0_p0;
            if (sync1_p1 == stable) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= sync1_p1;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Pulses are valid in the cycle before stable flips, so flags set on the
    // same edge that LEVEL changes.
    assign level      = stable;
    assign rise_pulse = accept &  sync1_p1;
    assign fall_pulse = accept & ~sync1_p1;

endmodule

// File: rtl/gpio_in.sv
// Memory-mapped GPIO input block: per-pin debounce, sticky edge flags with
// write-1-to-clear, edge-interrupt enable mask and a registered IRQ line.
module gpio_in
    import gpio_in_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 16,
    parameter logic [MXLEN-1:0] BASE_ADDR       = GPIN_BASE_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] PIN,
    input  logic [MXLEN-1:0] ADDR,
    input  logic             LOAD,
    input  logic             STORE,
    input  logic [MXLEN-1:0] WDATA,
    output logic [MXLEN-1:0] RDATA,
    output logic             IRQ
);

    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise_set;
    logic [WIDTH-1:0] fall_set;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] en;
    logic [WIDTH-1:0] rise_clr;
    logic [WIDTH-1:0] fall_clr;
    logic             en_wr;
    logic             hit;
    gpin_reg_e        reg_sel;
    logic             unused_bits;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        gpio_in_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk       (CLK),
            .rst_n     (RST),
            .pin       (PIN[i]),
            .level     (level[i]),
            .rise_pulse(rise_set[i]),
            .fall_pulse(fall_set[i])
        );
    end

    assign hit     = (ADDR[MXLEN-1:4] == BASE_ADDR[MXLEN-1:4]);
    assign reg_sel = gpin_reg_e'(ADDR[3:2]);

    // Byte lanes and upper store bits carry no meaning for this block.
    assign unused_bits = ^{ADDR[1:0], WDATA};

    always_comb begin
        RDATA = '0;
        if (hit && LOAD) begin
            case (reg_sel)
                REG_LEVEL: RDATA = MXLEN'(level);
                REG_RISE:  RDATA = MXLEN'(rise);
                REG_FALL:  RDATA = MXLEN'(fall);
                REG_EN:    RDATA = MXLEN'(en);
            endcase
        end
    end

    always_comb begin
        rise_clr = '0;
        fall_clr = '0;
        en_wr    = 1'b0;
        if (hit && STORE) begin
            case (reg_sel)
                REG_RISE:  rise_clr = WDATA[WIDTH-1:0];
                REG_FALL:  fall_clr = WDATA[WIDTH-1:0];
                REG_EN:    en_wr    = 1'b1;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rise <= '0;
            fall <= '0;
            en   <= '0;
            IRQ  <= 1'b0;
        end else begin
            // A new event on the clearing edge wins over the clear.
            rise <= (rise & ~rise_clr) | rise_set;
            fall <= (fall & ~fall_clr) | fall_set;
            if (en_wr) begin
                en <= WDATA[WIDTH-1:0];
            end
            IRQ <= |((rise | fall) & en);
        end
    end

endmodule

// File: tb/tb_gpio_in.sv
// Directed bench for gpio_in with a sample-window reference model checked
// every cycle, plus literal register expectations at the key instants.
`timescale 1ns/1ps
module tb_gpio_in;

    localparam int          W    = 4;
    localparam int          D    = 16;
    localparam logic [31:0] BASE = 32'h0000_2000;

    logic          CLK   = 1'b0;
    logic          RST   = 1'b0;
    logic [W-1:0]  PIN   = '0;
    logic [31:0]   ADDR  = '0;
    logic          LOAD  = 1'b0;
    logic          STORE = 1'b0;
    logic [31:0]   WDATA = '0;
    logic [31:0]   RDATA;
    logic          IRQ;

    int n_checks = 0;
    int n_fail   = 0;
    bit running  = 1'b1;

    gpio_in #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(D),
        .BASE_ADDR(BASE)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .PIN  (PIN),
        .ADDR (ADDR),
        .LOAD (LOAD),
        .STORE(STORE),
        .WDATA(WDATA),
        .RDATA(RDATA),
        .IRQ  (IRQ)
    );

    always #10 CLK = ~CLK;

    // Reference model: hist[0] is the pin sample from the previous edge.
    logic [W-1:0] hist [0:D];
    logic [W-1:0] m_level, m_rise, m_fall, m_en;
    logic         m_irq;
    logic [W-1:0] n_level, s_rise, s_fall, c_rise, c_fall;
    logic         all_opp, m_hit;

    task automatic model_reset();
        for (int k = 0; k <= D; k++) hist[k] = '0;
        m_level = '0; m_rise = '0; m_fall = '0; m_en = '0; m_irq = 1'b0;
    endtask

    function automatic logic [31:0] model_rdata();
        logic [31:0] r;
        r = 32'h0;
        if (ADDR[31:4] == BASE[31:4] && LOAD) begin
            case (ADDR[3:2])
                2'd0: r = 32'(m_level);
                2'd1: r = 32'(m_rise);
                2'd2: r = 32'(m_fall);
                default: r = 32'(m_en);
            endcase
        end
        return r;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge CLK or negedge RST);
            if (!RST) begin
                model_reset();
            end else begin
                n_level = m_level; s_rise = '0; s_fall = '0;
                // Accept when the last D synchronized samples all oppose the level.
                for (int i = 0; i < W; i++) begin
                    all_opp = 1'b1;
                    for (int k = 1; k <= D; k++)
                        if (hist[k][i] == m_level[i]) all_opp = 1'b0;
                    if (all_opp) begin
                        n_level[i] = ~m_level[i];
                        if (n_level[i]) s_rise[i] = 1'b1;
                        else            s_fall[i] = 1'b1;
                    end
                end
                m_hit = (ADDR[31:4] == BASE[31:4]) && STORE;
                c_rise = (m_hit && ADDR[3:2] == 2'd1) ? WDATA[W-1:0] : '0;
                c_fall = (m_hit && ADDR[3:2] == 2'd2) ? WDATA[W-1:0] : '0;
                m_irq  = |((m_rise | m_fall) & m_en);
                if (m_hit && ADDR[3:2] == 2'd3) m_en = WDATA[W-1:0];
                m_rise = (m_rise & ~c_rise) | s_rise;
                m_fall = (m_fall & ~c_fall) | s_fall;
                m_level = n_level;
                for (int k = D; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = PIN;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (running) begin
            chk("model_rdata", RDATA, model_rdata());
            chk("model_irq", 32'(IRQ), 32'(m_irq));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic rd(input logic [1:0] off, input string name, input logic [31:0] exp);
        ADDR = BASE | {28'h0, off, 2'b00};
        LOAD = 1'b1;
        #1;
        chk(name, RDATA, exp);
        LOAD = 1'b0;
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] data);
        ADDR  = BASE | {28'h0, off, 2'b00};
        WDATA = data;
        STORE = 1'b1;
        tick(1);
        STORE = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(3);
        rd(2'd0, "reset_level", 32'h0);
        chk("reset_irq", 32'(IRQ), 32'h0);
        RST = 1'b1;
        tick(40);
        rd(2'd0, "idle_level", 32'h0);
        rd(2'd1, "idle_rise", 32'h0);
        rd(2'd2, "idle_fall", 32'h0);
        chk("idle_irq", 32'(IRQ), 32'h0);

        // Pin 2 rises: accepted on edge 18, not 17
        PIN = 4'b0100;
        tick(17);
        rd(2'd0, "p2_level_e17", 32'h0);
        rd(2'd1, "p2_rise_e17", 32'h0);
        tick(1);
        rd(2'd0, "p2_level_e18", 32'h4);
        rd(2'd1, "p2_rise_e18", 32'h4);

        // Short pulse on pin 0 is filtered
        PIN = 4'b0101;
        tick(10);
        PIN = 4'b0100;
        tick(30);
        rd(2'd0, "glitch_level", 32'h4);
        rd(2'd1, "glitch_rise", 32'h4);
        rd(2'd2, "glitch_fall", 32'h0);

        // Clear, fall, clear, then enable and rise with IRQ
        wr(2'd1, 32'h4);
        rd(2'd1, "w1c_rise", 32'h0);
        PIN = 4'b0000;
        tick(20);
        rd(2'd2, "p2_fall", 32'h4);
        wr(2'd2, 32'h4);
        rd(2'd2, "w1c_fall", 32'h0);
        wr(2'd3, 32'h4);
        rd(2'd3, "en_read", 32'h4);
        PIN = 4'b0100;
        tick(17);
        chk("irq_pre_flag", 32'(IRQ), 32'h0);
        tick(1);
        rd(2'd1, "irq_flag_set", 32'h4);
        chk("irq_same_edge", 32'(IRQ), 32'h0);
        tick(1);
        chk("irq_high", 32'(IRQ), 32'h1);
        ADDR = BASE | 32'h4; WDATA = 32'h4; LOAD = 1'b1; STORE = 1'b1;
        #1;
        chk("load_store_pre", RDATA, 32'h4);
        tick(1);
        STORE = 1'b0;
        #1;
        chk("load_store_post", RDATA, 32'h0);
        LOAD = 1'b0;
        chk("irq_after_w1c", 32'(IRQ), 32'h1);
        tick(1);
        chk("irq_dropped", 32'(IRQ), 32'h0);

        // W1C of RISE[1] on the edge the new rise is accepted
        PIN = 4'b0110;
        tick(17);
        wr(2'd1, 32'h2);
        rd(2'd1, "set_wins", 32'h2);
        rd(2'd0, "set_wins_level", 32'h6);

        // Reset at debounce count 12 on pin 3
        PIN = 4'b1110;
        tick(14);
        RST = 1'b0;
        #1;
        chk("rst_irq", 32'(IRQ), 32'h0);
        tick(2);
        RST = 1'b1;
        rd(2'd0, "rst_level", 32'h0);
        tick(17);
        rd(2'd0, "rst_level_e17", 32'h0);
        tick(1);
        rd(2'd0, "rst_level_e18", 32'he);
        rd(2'd1, "rst_rise_e18", 32'he);
        rd(2'd3, "rst_en", 32'h0);

        // Register-map corners
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd3, "en_width", 32'hF);
        wr(2'd0, 32'h0);
        rd(2'd0, "level_ro", 32'he);
        ADDR = BASE + 32'h10; LOAD = 1'b1;
        #1;
        chk("miss_read", RDATA, 32'h0);
        ADDR = BASE | 32'h3;
        #1;
        chk("byte_lane_read", RDATA, 32'he);
        LOAD = 1'b0;
        tick(1);
        chk("irq_en_all", 32'(IRQ), 32'h1);
        tick(2);

        running = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
